riscv_core_mul_iter: RTL and testbench



---
 rtl/riscv_core_mul_pkg.sv | 16 +
 rtl/riscv_core_mul_mag.sv | 42 ++++
 rtl/riscv_core_mul_iter.sv | 128 ++++++++++++
 tb/tb_riscv_core_mul_iter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_mul_pkg.sv
// Shared op encodings and FSM state type for the iterative RV64M multiplier.
package riscv_core_mul_pkg;

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;
  localparam logic [1:0] MULW   = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/riscv_core_mul_mag.sv
// Operand magnitude for the shift-add multiplier: abs or raw depending on the
// op and which source this is; word ops take abs of the low half.
module riscv_core_mul_mag
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] operand,
  input  logic [1:0]      control,
  input  logic            isword,
  input  logic            is_srcA,
  output logic [XLEN-1:0] magnitude
);

  localparam int HALF = XLEN / 2;

  logic [HALF-1:0] lo;
  logic [HALF-1:0] lo_abs;
  logic [XLEN-1:0] full_abs;
  logic            take_abs;

  always_comb begin
    lo       = operand[HALF-1:0];
    lo_abs   = lo[HALF-1] ? (~lo + HALF'(1)) : lo;
    full_abs = operand[XLEN-1] ? (~operand + XLEN'(1)) : operand;

    // MULHSU only treats rs1 as signed; MULHU treats neither.
    take_abs = 1'b1;
    if (control == MULHU) begin
      take_abs = 1'b0;
    end else if (control == MULHSU) begin
      take_abs = is_srcA;
    end

    if (isword) begin
      magnitude = {{HALF{1'b0}}, lo_abs};
    end else begin
      magnitude = take_abs ? full_abs : operand;
    end
  end

endmodule

// File: rtl/riscv_core_mul_iter.sv
// Iterative unsigned shift-add multiplier producing the 2*XLEN magnitude product.
// Optional RISCV_CORE_MUL_ZERO_SKIP_EN: zero magnitude operands bypass BUSY.
//
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | consuming BITS_PER_CYCLE multiplier bits per cycle
//   DONE  | product valid, held until ack
module riscv_core_mul_iter
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mul_valid,
  output logic              o_mul_ready,
  input  logic [XLEN-1:0]   i_mul_srcA,
  input  logic [XLEN-1:0]   i_mul_srcB,
  input  logic [1:0]        i_mul_control,
  input  logic              i_mul_isword,
  input  logic              i_mul_flush,
  output logic              o_mul_valid,
  input  logic              i_mul_ack,
  output logic              o_mul_srcA_Dsign,
  output logic              o_mul_srcB_Dsign,
  output logic              o_mul_srcA_Wsign,
  output logic              o_mul_srcB_Wsign,
  output logic [1:0]        o_mul_control,
  output logic              o_mul_isword,
  output logic [2*XLEN-1:0] o_mul_product,
  output logic              o_mul_busy
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = XLEN / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  mul_state_t state_q, state_d;

  logic [2*XLEN-1:0] p_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [CW-1:0]     cnt_q;
  logic [XLEN+BPC-1:0] upper;
  logic              accept;
  logic              zero_op;
  logic              last_step;

  riscv_core_mul_mag #(.XLEN(XLEN)) u_mag_a (
    .operand   (i_mul_srcA),
    .control   (i_mul_control),
    .isword    (i_mul_isword),
    .is_srcA   (1'b1),
    .magnitude (mag_a)
  );

  riscv_core_mul_mag #(.XLEN(XLEN)) u_mag_b (
    .operand   (i_mul_srcB),
    .control   (i_mul_control),
    .isword    (i_mul_isword),
    .is_srcA   (1'b0),
    .magnitude (mag_b)
  );

`ifdef RISCV_CORE_MUL_ZERO_SKIP_EN
  assign zero_op = (mag_a == '0) || (mag_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && i_mul_valid && !i_mul_flush;
  assign last_step = (cnt_q == CW'(1));

  // One partial-product step: multiplicand times the low BPC multiplier bits.
  assign upper = {{BPC{1'b0}}, p_q[2*XLEN-1:XLEN]}
               + ({{BPC{1'b0}}, mag_a_q} * {{XLEN{1'b0}}, p_q[BPC-1:0]});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_mul_valid) state_d = zero_op ? DONE : BUSY;
      BUSY:    if (last_step)   state_d = DONE;
      DONE:    if (i_mul_ack)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_mul_flush) state_d = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      p_q              <= '0;
      mag_a_q          <= '0;
      cnt_q            <= '0;
      o_mul_srcA_Dsign <= 1'b0;
      o_mul_srcB_Dsign <= 1'b0;
      o_mul_srcA_Wsign <= 1'b0;
      o_mul_srcB_Wsign <= 1'b0;
      o_mul_control    <= 2'b00;
      o_mul_isword     <= 1'b0;
    end else if (accept) begin
      o_mul_srcA_Dsign <= i_mul_srcA[XLEN-1];
      o_mul_srcB_Dsign <= i_mul_srcB[XLEN-1];
      o_mul_srcA_Wsign <= i_mul_srcA[XLEN/2-1];
      o_mul_srcB_Wsign <= i_mul_srcB[XLEN/2-1];
      o_mul_control    <= i_mul_control;
      o_mul_isword     <= i_mul_isword;
      mag_a_q          <= mag_a;
      p_q              <= zero_op ? '0 : {{XLEN{1'b0}}, mag_b};
      cnt_q            <= i_mul_isword ? CW'(STEPS / 2) : CW'(STEPS);
    end else if ((state_q == BUSY) && !i_mul_flush) begin
      p_q   <= {upper, p_q[XLEN-1:BPC]};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // A word op stops after half the steps, leaving its product XLEN/2 bits high.
  assign o_mul_product = o_mul_isword ? (p_q >> (XLEN / 2)) : p_q;
  assign o_mul_ready   = (state_q == IDLE);
  assign o_mul_valid   = (state_q == DONE);
  assign o_mul_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_core_mul_iter.sv
// Scoreboard bench for riscv_core_mul_iter: directed and random requests checked
// against an arithmetic reference; also honours RISCV_CORE_MUL_ZERO_SKIP_EN.
module tb_riscv_core_mul_iter;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_mul_valid;
  logic         o_mul_ready;
  logic [63:0]  i_mul_srcA;
  logic [63:0]  i_mul_srcB;
  logic [1:0]   i_mul_control;
  logic         i_mul_isword;
  logic         i_mul_flush;
  logic         o_mul_valid;
  logic         i_mul_ack;
  logic         o_mul_srcA_Dsign;
  logic         o_mul_srcB_Dsign;
  logic         o_mul_srcA_Wsign;
  logic         o_mul_srcB_Wsign;
  logic [1:0]   o_mul_control;
  logic         o_mul_isword;
  logic [127:0] o_mul_product;
  logic         o_mul_busy;

  riscv_core_mul_iter #(.XLEN(64), .BITS_PER_CYCLE(4)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_mul_valid      (i_mul_valid),
    .o_mul_ready      (o_mul_ready),
    .i_mul_srcA       (i_mul_srcA),
    .i_mul_srcB       (i_mul_srcB),
    .i_mul_control    (i_mul_control),
    .i_mul_isword     (i_mul_isword),
    .i_mul_flush      (i_mul_flush),
    .o_mul_valid      (o_mul_valid),
    .i_mul_ack        (i_mul_ack),
    .o_mul_srcA_Dsign (o_mul_srcA_Dsign),
    .o_mul_srcB_Dsign (o_mul_srcB_Dsign),
    .o_mul_srcA_Wsign (o_mul_srcA_Wsign),
    .o_mul_srcB_Wsign (o_mul_srcB_Wsign),
    .o_mul_control    (o_mul_control),
    .o_mul_isword     (o_mul_isword),
    .o_mul_product    (o_mul_product),
    .o_mul_busy       (o_mul_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] product;
    logic         dsign_a, dsign_b, wsign_a, wsign_b;
    logic [1:0]   control;
    logic         isword;
    int           exp_cyc;
    int           ack_dly;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   failed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] abs64(input logic [63:0] v);
    return v[63] ? (64'd0 - v) : v;
  endfunction

  // Reference: magnitudes from signed interpretation, then a plain 128-bit multiply.
  function automatic logic [127:0] ref_product(input logic [63:0] a, input logic [63:0] b,
                                               input logic [1:0] ctl, input logic w,
                                               output logic zero);
    logic [63:0] ma, mb;
    logic signed [31:0] sa, sb;
    longint la, lb;
    if (w) begin
      sa = a[31:0];
      sb = b[31:0];
      la = sa;
      lb = sb;
      ma = abs64(la);
      mb = abs64(lb);
    end else if (ctl == 2'b11) begin
      ma = a;
      mb = b;
    end else if (ctl == 2'b10) begin
      ma = abs64(a);
      mb = b;
    end else begin
      ma = abs64(a);
      mb = abs64(b);
    end
    zero = (ma == 64'd0) || (mb == 64'd0);
    return {64'd0, ma} * {64'd0, mb};
  endfunction

  // Returns 1 when ready appeared within the budget; driver is at a negedge.
  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!o_mul_ready && t < 300) begin
      @(negedge i_clk);
      t++;
    end
    ok = o_mul_ready;
    if (!ok) begin
      tests++;
      failed++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1");
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ctl,
                       input logic w, input int ack_dly);
    exp_t e;
    bit ok;
    logic zero;
    int lat;
    wait_ready(ok);
    if (ok) begin
      e.product = ref_product(a, b, ctl, w, zero);
      e.dsign_a = a[63];
      e.dsign_b = b[63];
      e.wsign_a = a[31];
      e.wsign_b = b[31];
      e.control = ctl;
      e.isword  = w;
      lat = w ? 8 : 16;
`ifdef RISCV_CORE_MUL_ZERO_SKIP_EN
      if (zero) lat = 0;
`endif
      // lat counts clock edges after the accept edge before valid is visible.
      e.exp_cyc = cyc + 1 + lat;
      e.ack_dly = ack_dly;
      sb_q.push_back(e);
      i_mul_srcA    = a;
      i_mul_srcB    = b;
      i_mul_control = ctl;
      i_mul_isword  = w;
      i_mul_valid   = 1'b1;
      @(negedge i_clk);
      i_mul_valid   = 1'b0;
      i_mul_srcA    = {$urandom, $urandom};
      i_mul_srcB    = {$urandom, $urandom};
    end
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'($urandom_range(0, 15));
      4:       return {32'($urandom), 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: compares held outputs every valid cycle, then acks after the entry's delay.
  initial begin
    bit first = 1'b1;
    int wait_cnt = 0;
    i_mul_ack = 1'b0;
    forever begin
      @(negedge i_clk);
      i_mul_ack = 1'b0;
      if (o_mul_valid) begin
        if (sb_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_valid: got valid=1 expected valid=0");
        end else begin
          if (first) begin
            chk("latency", 128'(cyc), 128'(sb_q[0].exp_cyc));
            wait_cnt = sb_q[0].ack_dly;
            first = 1'b0;
          end
          chk("product", o_mul_product, sb_q[0].product);
          chk("srcA_Dsign", 128'(o_mul_srcA_Dsign), 128'(sb_q[0].dsign_a));
          chk("srcB_Dsign", 128'(o_mul_srcB_Dsign), 128'(sb_q[0].dsign_b));
          chk("srcA_Wsign", 128'(o_mul_srcA_Wsign), 128'(sb_q[0].wsign_a));
          chk("srcB_Wsign", 128'(o_mul_srcB_Wsign), 128'(sb_q[0].wsign_b));
          chk("control", 128'(o_mul_control), 128'(sb_q[0].control));
          chk("isword", 128'(o_mul_isword), 128'(sb_q[0].isword));
          chk("ready_in_done", 128'(o_mul_ready), 128'd0);
          chk("busy_in_done", 128'(o_mul_busy), 128'd1);
          if (wait_cnt == 0) begin
            i_mul_ack = 1'b1;
            void'(sb_q.pop_front());
            first = 1'b1;
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    int t;
    i_rst_n       = 1'b0;
    i_mul_valid   = 1'b0;
    i_mul_flush   = 1'b0;
    i_mul_srcA    = '0;
    i_mul_srcB    = '0;
    i_mul_control = 2'b00;
    i_mul_isword  = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_ready", 128'(o_mul_ready), 128'd1);
    chk("reset_valid", 128'(o_mul_valid), 128'd0);
    chk("reset_busy", 128'(o_mul_busy), 128'd0);
    chk("reset_product", o_mul_product, 128'd0);
    chk("reset_signs", 128'({o_mul_srcA_Dsign, o_mul_srcB_Dsign, o_mul_srcA_Wsign,
                             o_mul_srcB_Wsign, o_mul_control, o_mul_isword}), 128'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b00, 1'b0, 2);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 0);
    issue(64'h0000_0001_8000_0000, 64'd2, 2'b00, 1'b1, 0);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 5);
    issue(64'hFFFF_FFFF_FFFF_FFF0, 64'h7, 2'b10, 1'b0, 1);
    issue(64'h1234_5678_9ABC_DEF0, 64'd0, 2'b00, 1'b0, 0);

    // Flush part-way through BUSY: result must vanish and the block return to IDLE.
    wait_ready(ok);
    if (ok) begin
      i_mul_srcA    = 64'd12345;
      i_mul_srcB    = 64'd678;
      i_mul_control = 2'b00;
      i_mul_isword  = 1'b0;
      i_mul_valid   = 1'b1;
      @(negedge i_clk);
      i_mul_valid = 1'b0;
      repeat (4) @(negedge i_clk);
      chk("busy_before_flush", 128'(o_mul_busy), 128'd1);
      i_mul_flush = 1'b1;
      i_mul_valid = 1'b1;
      @(negedge i_clk);
      i_mul_flush = 1'b0;
      i_mul_valid = 1'b0;
      chk("busy_after_flush", 128'(o_mul_busy), 128'd0);
      chk("ready_after_flush", 128'(o_mul_ready), 128'd1);
      chk("valid_after_flush", 128'(o_mul_valid), 128'd0);
      repeat (20) @(negedge i_clk);
    end
    issue(64'd3, 64'd7, 2'b11, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] ctl;
      logic       w;
      ctl = 2'($urandom_range(0, 3));
      w   = (ctl == 2'b00) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(rand_opnd(), rand_opnd(), ctl, w, $urandom_range(0, 4));
    end

    t = 0;
    while ((sb_q.size() != 0 || !o_mul_ready) && t < 300) begin
      @(negedge i_clk);
      t++;
    end
    chk("drain_pending", 128'(sb_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
